// File: rtl/ex_mem_stage_if.sv
// Execute-to-memory stage bundle: the upstream accept handshake, the downstream
// MEM handshake, the flag inputs/outputs and the condition evaluation.
interface ex_mem_stage_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_negative;
  logic             in_zero;
  logic             in_overflow;
  logic             in_carry_out;
  logic             in_set_flags;
  logic [4:0]       in_rd;
  logic             in_reg_write;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [4:0]       out_rd;
  logic             out_reg_write;
  logic             flag_n;
  logic             flag_z;
  logic             flag_v;
  logic             flag_c;
  logic [3:0]       cond;
  logic             cond_true;

  modport master (
    output in_valid, in_result, in_negative, in_zero, in_overflow, in_carry_out,
           in_set_flags, in_rd, in_reg_write, flush, out_ready, cond,
    input  in_ready, out_valid, out_result, out_rd, out_reg_write,
           flag_n, flag_z, flag_v, flag_c, cond_true
  );

  modport slave (
    input  in_valid, in_result, in_negative, in_zero, in_overflow, in_carry_out,
           in_set_flags, in_rd, in_reg_write, flush, out_ready, cond,
    output in_ready, out_valid, out_result, out_rd, out_reg_write,
           flag_n, flag_z, flag_v, flag_c, cond_true
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer (main + skid),
// architectural NZVC flags and ARM condition-code evaluation.
module ex_mem_stage #(
  parameter int WIDTH = 64
) (
  input  logic         clk,
  input  logic         reset,
  ex_mem_stage_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [4:0]       rd;
    logic             reg_write;
  } entry_t;

  entry_t     main_q, skid_q, in_e;
  logic       main_valid, skid_valid;
  logic [3:0] flags_q;   // {N,Z,V,C}
  logic [3:0] flags_in, flags_eff;
  logic       accept, send;

  assign in_e     = '{result: bus.in_result, rd: bus.in_rd, reg_write: bus.in_reg_write};
  assign flags_in = {bus.in_negative, bus.in_zero, bus.in_overflow, bus.in_carry_out};

  // in_ready comes straight off skid_valid, so out_ready never reaches it.
  assign accept = bus.in_valid && !skid_valid && !bus.flush;
  assign send   = main_valid && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || send) begin
      // A full skid blocks accepts, so skid promotion never races a new entry.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= in_e;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= in_e;
      skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      flags_q <= 4'b0000;
    else if (accept && bus.in_set_flags)
      flags_q <= flags_in;
  end

  assign flags_eff = (accept && bus.in_set_flags) ? flags_in : flags_q;

  logic n, z, v, c;
  assign {n, z, v, c} = flags_eff;

  always_comb begin
    bus.cond_true = 1'b1;
    case (bus.cond)
      4'h0: bus.cond_true = z;
      4'h1: bus.cond_true = !z;
      4'h2: bus.cond_true = c;
      4'h3: bus.cond_true = !c;
      4'h4: bus.cond_true = n;
      4'h5: bus.cond_true = !n;
      4'h6: bus.cond_true = v;
      4'h7: bus.cond_true = !v;
      4'h8: bus.cond_true = c && !z;
      4'h9: bus.cond_true = !(c && !z);
      4'hA: bus.cond_true = (n == v);
      4'hB: bus.cond_true = (n != v);
      4'hC: bus.cond_true = !z && (n == v);
      4'hD: bus.cond_true = !(!z && (n == v));
      default: bus.cond_true = 1'b1;
    endcase
  end

  assign bus.in_ready      = !skid_valid;
  assign bus.out_valid     = main_valid;
  assign bus.out_result    = main_q.result;
  assign bus.out_rd        = main_q.rd;
  assign bus.out_reg_write = main_valid && main_q.reg_write;
  assign {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} = flags_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a negedge scoreboard tracks every
// accepted entry and checks ordering/handshake, scenario tasks check the rest.
module tb_ex_mem_stage;
  localparam int WIDTH = 64;
  localparam int EW    = WIDTH + 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [EW-1:0] sbq[$];

  ex_mem_stage_if #(.WIDTH(WIDTH)) bus ();
  ex_mem_stage #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [WIDTH-1:0] res, input logic [4:0] rd,
                       input logic rw, input logic sf, input logic [3:0] nzvc);
    bus.in_valid     = vld;
    bus.in_result    = res;
    bus.in_rd        = rd;
    bus.in_reg_write = rw;
    bus.in_set_flags = sf;
    {bus.in_negative, bus.in_zero, bus.in_overflow, bus.in_carry_out} = nzvc;
  endtask

  task automatic monitor();
    logic [EW-1:0] got;
    forever begin
      @(negedge clk);
      if (reset) begin
        sbq.delete();
        continue;
      end
      vectors++;
      if (bus.in_ready !== (sbq.size() < 2)) begin
        miscompares++;
        $display("FAIL sb_in_ready: got %b want %b", bus.in_ready, sbq.size() < 2);
      end
      vectors++;
      if (bus.out_valid !== (sbq.size() != 0)) begin
        miscompares++;
        $display("FAIL sb_out_valid: got %b want %b", bus.out_valid, sbq.size() != 0);
      end
      if (bus.out_valid !== 1'b1) begin
        vectors++;
        if (bus.out_reg_write !== 1'b0) begin
          miscompares++;
          $display("FAIL sb_idle_reg_write: got %b want 0", bus.out_reg_write);
        end
      end else if (sbq.size() != 0) begin
        got = {bus.out_result, bus.out_rd, bus.out_reg_write};
        vectors++;
        if (got !== sbq[0]) begin
          miscompares++;
          $display("FAIL sb_data: got %h want %h", got, sbq[0]);
        end
        if (bus.out_ready) void'(sbq.pop_front());
      end
      if (bus.flush)
        sbq.delete();
      else if (bus.in_valid && bus.in_ready)
        sbq.push_back({bus.in_result, bus.in_rd, bus.in_reg_write});
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.out_reg_write, bus.flag_n, bus.flag_z,
         bus.flag_v, bus.flag_c} !== 7'b0100000 || bus.out_result !== '0 || bus.out_rd !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_state: vld=%b rdy=%b rw=%b nzvc=%b res=%h rd=%0d want 0,1,0,0000,0,0",
               bus.out_valid, bus.in_ready, bus.out_reg_write,
               {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}, bus.out_result, bus.out_rd);
    end
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    drive(1'b1, 64'h5, 5'd3, 1'b1, 1'b0, 4'b0000);
    cyc();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 64'h5 || bus.out_rd !== 5'd3 || bus.out_reg_write !== 1'b1) begin
      miscompares++;
      $display("FAIL first_latency: vld=%b res=%h rd=%0d want 1,5,3", bus.out_valid, bus.out_result, bus.out_rd);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, {$urandom, $urandom}, 5'($urandom), 1'($urandom), 1'b0, 4'b0000);
      cyc();
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_rate: rdy=%b vld=%b want 1,1", bus.in_ready, bus.out_valid);
      end
    end
    drive(1'b0, '0, 5'd0, 1'b0, 1'b0, 4'b0000);
    cyc();
    cyc();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h1, 5'd7, 1'b1, 1'b0, 4'b0000);
    cyc();
    drive(1'b1, 64'h2, 5'd9, 1'b0, 1'b0, 4'b0000);
    cyc();
    drive(1'b0, '0, 5'd0, 1'b0, 1'b0, 4'b0000);
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_result !== 64'h1) begin
      miscompares++;
      $display("FAIL bp_full: rdy=%b res=%h want 0,1", bus.in_ready, bus.out_result);
    end
    cyc();
    cyc();
    bus.out_ready = 1'b1;
    cyc();
    vectors++;
    if (bus.out_result !== 64'h2 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_drain: res=%h rdy=%b vld=%b want 2,1,1", bus.out_result, bus.in_ready, bus.out_valid);
    end
    cyc();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_empty: vld=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_flags();
    bus.out_ready = 1'b1;
    bus.cond = 4'h0;
    drive(1'b1, 64'hAA, 5'd1, 1'b1, 1'b1, 4'b0101);
    #1;
    vectors++;
    if (bus.cond_true !== 1'b1) begin
      miscompares++;
      $display("FAIL flags_bypass_eq: got %b want 1", bus.cond_true);
    end
    cyc();
    vectors++;
    if ({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b0101) begin
      miscompares++;
      $display("FAIL flags_set: got %b want 0101", {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});
    end
    drive(1'b1, 64'hBB, 5'd2, 1'b1, 1'b0, 4'b1010);
    #1;
    vectors++;
    if (bus.cond_true !== 1'b1) begin
      miscompares++;
      $display("FAIL flags_reg_eq: got %b want 1", bus.cond_true);
    end
    cyc();
    drive(1'b0, '0, 5'd0, 1'b0, 1'b0, 4'b0000);
    vectors++;
    if ({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b0101) begin
      miscompares++;
      $display("FAIL flags_hold: got %b want 0101", {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});
    end
    cyc();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h11, 5'd4, 1'b1, 1'b0, 4'b0000);
    cyc();
    drive(1'b1, 64'h22, 5'd5, 1'b1, 1'b0, 4'b0000);
    cyc();
    drive(1'b1, 64'hDEAD, 5'd6, 1'b1, 1'b1, 4'b1111);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    drive(1'b0, '0, 5'd0, 1'b0, 1'b0, 4'b0000);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b0101) begin
      miscompares++;
      $display("FAIL flush_full: vld=%b rdy=%b nzvc=%b want 0,1,0101", bus.out_valid, bus.in_ready,
               {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});
    end
    // Flush with an otherwise-acceptable input into an empty stage.
    drive(1'b1, 64'hBEEF, 5'd8, 1'b1, 1'b1, 4'b1111);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    drive(1'b0, '0, 5'd0, 1'b0, 1'b0, 4'b0000);
    vectors++;
    if (bus.out_valid !== 1'b0 || {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b0101) begin
      miscompares++;
      $display("FAIL flush_ignore_accept: vld=%b nzvc=%b want 0,0101", bus.out_valid,
               {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});
    end
    bus.out_ready = 1'b1;
    drive(1'b1, 64'h33, 5'd10, 1'b1, 1'b0, 4'b0000);
    cyc();
    drive(1'b0, '0, 5'd0, 1'b0, 1'b0, 4'b0000);
    cyc();
  endtask

  task automatic test_cond_sweep();
    logic [15:0] want_reg;
    logic [15:0] want_byp;
    want_reg = 16'b1110_1010_1001_1010; // bit i = cond i, flags 1000
    want_byp = 16'b1110_1010_0110_0101; // bit i = cond i, flags 0111
    bus.out_ready = 1'b1;
    drive(1'b1, 64'h44, 5'd11, 1'b0, 1'b1, 4'b1000);
    cyc();
    drive(1'b0, '0, 5'd0, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      bus.cond = 4'(i);
      #1;
      vectors++;
      if (bus.cond_true !== want_reg[i]) begin
        miscompares++;
        $display("FAIL cond_reg[%0d]: got %b want %b", i, bus.cond_true, want_reg[i]);
      end
    end
    cyc();
    for (int i = 0; i < 16; i++) begin
      bus.cond = 4'(i);
      drive(1'b1, 64'h0, 5'd0, 1'b0, 1'b1, 4'b0111);
      #1;
      vectors++;
      if (bus.cond_true !== want_byp[i]) begin
        miscompares++;
        $display("FAIL cond_byp[%0d]: got %b want %b", i, bus.cond_true, want_byp[i]);
      end
      drive(1'b0, '0, 5'd0, 1'b0, 1'b0, 4'b0000);
      cyc();
    end
    vectors++;
    if ({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b1000) begin
      miscompares++;
      $display("FAIL cond_flags_kept: got %b want 1000", {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h55, 5'd12, 1'b1, 1'b0, 4'b0000);
    cyc();
    drive(1'b1, 64'h66, 5'd13, 1'b1, 1'b0, 4'b0000);
    cyc();
    drive(1'b0, '0, 5'd0, 1'b0, 1'b0, 4'b0000);
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_reg_write !== 1'b0 ||
        {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_reset: vld=%b rdy=%b rw=%b nzvc=%b want 0,1,0,0000", bus.out_valid,
               bus.in_ready, bus.out_reg_write, {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});
    end
    cyc();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 64'h77, 5'd14, 1'b1, 1'b0, 4'b0000);
    cyc();
    drive(1'b0, '0, 5'd0, 1'b0, 1'b0, 4'b0000);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 64'h77) begin
      miscompares++;
      $display("FAIL post_reset_accept: vld=%b res=%h want 1,77", bus.out_valid, bus.out_result);
    end
    cyc();
    cyc();
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    bus.cond = 4'h0;
    drive(1'b0, '0, 5'd0, 1'b0, 1'b0, 4'b0000);
    fork
      monitor();
    join_none
    test_reset();
    test_stream();
    test_backpressure();
    test_flags();
    test_flush();
    test_cond_sweep();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
